// File: rtl/spike_dec_pkg.sv
// Shared types and rate scaling for the spike-rate decoder.
// Optional sum beat controlled by SPIKE_DEC_SUM_EN (see spike_rate_decoder).
package spike_dec_pkg;

  localparam int RATE_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } dec_state_e;

  // Spike count to fixed-point rate: left shift, clamp to full scale.
  function automatic logic [RATE_W-1:0] rate_scale(input logic [31:0] cnt, input int shift);
    logic [47:0] wide;
    wide = 48'(cnt) << shift;
    if (wide[47:RATE_W] != '0)
      return '1;
    return wide[RATE_W-1:0];
  endfunction

endpackage

// File: rtl/spike_win_counter.sv
// Per-channel spike counters over a window of WIN_LEN enabled cycles.
// Emits a close strobe with the window totals (closing-cycle spikes included).
module spike_win_counter #(
  parameter  int N_CH    = 8,
  parameter  int WIN_LEN = 32,
  localparam int CNT_W   = $clog2(WIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CH-1:0]       spike_in,
  output logic                  win_close,
  output logic [N_CH*CNT_W-1:0] snap
);

  localparam int WC_W = $clog2(WIN_LEN);

  logic [WC_W-1:0]  win_cnt;
  logic [CNT_W-1:0] cnt [N_CH];

  assign win_close = en && (win_cnt == WC_W'(WIN_LEN - 1));

  always_comb begin
    snap = '0;
    for (int c = 0; c < N_CH; c++)
      snap[c*CNT_W +: CNT_W] = cnt[c] + CNT_W'(spike_in[c]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt <= '0;
      for (int c = 0; c < N_CH; c++)
        cnt[c] <= '0;
    end else if (en) begin
      win_cnt <= win_close ? '0 : win_cnt + 1'b1;
      for (int c = 0; c < N_CH; c++)
        cnt[c] <= win_close ? '0 : cnt[c] + CNT_W'(spike_in[c]);
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train to rate decoder: windowed counts streamed out as 16-bit rates.
// Define SPIKE_DEC_SUM_EN to append a population-sum beat to every drain.
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter  int N_CH    = 8,
  parameter  int WIN_LEN = 32,
  localparam int CNT_W   = $clog2(WIN_LEN + 1),
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_CH-1:0]   spike_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [RATE_W-1:0] out_rate,
`ifdef SPIKE_DEC_SUM_EN
  output logic              sum_beat,
`endif
  output logic              out_last,
  output logic              overrun
);

  localparam int SHIFT = RATE_W - $clog2(WIN_LEN);

  dec_state_e             state;
  logic                   win_close;
  logic [N_CH*CNT_W-1:0]  snap;
  logic [CNT_W-1:0]       snap_q [N_CH];
  logic                   xfer;
  logic                   busy;

  spike_win_counter #(
    .N_CH    (N_CH),
    .WIN_LEN (WIN_LEN)
  ) u_win (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .spike_in  (spike_in),
    .win_close (win_close),
    .snap      (snap)
  );

  assign xfer = out_valid && out_ready;
  // A last-beat transfer frees the shadow registers on the same edge.
  assign busy = (state == DRAIN) && !(xfer && out_last);

`ifdef SPIKE_DEC_SUM_EN
  logic [31:0] sum_cnt;

  always_comb begin
    sum_cnt = '0;
    for (int c = 0; c < N_CH; c++)
      sum_cnt = sum_cnt + 32'(snap_q[c]);
  end

  assign out_last = out_valid && sum_beat;
  assign out_rate = sum_beat ? rate_scale(sum_cnt, SHIFT)
                             : rate_scale(32'(snap_q[out_ch]), SHIFT);
`else
  assign out_last = out_valid && (out_ch == CH_W'(N_CH - 1));
  assign out_rate = rate_scale(32'(snap_q[out_ch]), SHIFT);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_ch    <= '0;
      overrun   <= 1'b0;
      for (int c = 0; c < N_CH; c++)
        snap_q[c] <= '0;
`ifdef SPIKE_DEC_SUM_EN
      sum_beat  <= 1'b0;
`endif
    end else begin
      if (win_close && busy)
        overrun <= 1'b1;
      if (win_close && !busy) begin
        for (int c = 0; c < N_CH; c++)
          snap_q[c] <= snap[c*CNT_W +: CNT_W];
      end
      case (state)
        IDLE: begin
          if (win_close) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
            out_ch    <= '0;
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (out_last) begin
              out_ch <= '0;
`ifdef SPIKE_DEC_SUM_EN
              sum_beat <= 1'b0;
`endif
              if (!win_close) begin
                state     <= IDLE;
                out_valid <= 1'b0;
              end
            end else begin
`ifdef SPIKE_DEC_SUM_EN
              if (out_ch == CH_W'(N_CH - 1)) begin
                sum_beat <= 1'b1;
                out_ch   <= '0;
              end else begin
                out_ch <= out_ch + 1'b1;
              end
`else
              out_ch <= out_ch + 1'b1;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder (default build): windowed-count model
// with an expected-beat queue, plus literal checks on hand-computed beats.
module tb_spike_rate_decoder;

  localparam int N_CH    = 8;
  localparam int WIN_LEN = 32;

  logic            clk;
  logic            rst;
  logic            en;
  logic [N_CH-1:0] spike_in;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_ch;
  logic [15:0]     out_rate;
  logic            out_last;
  logic            overrun;

  int vectors     = 0;
  int miscompares = 0;

  spike_rate_decoder #(
    .N_CH    (N_CH),
    .WIN_LEN (WIN_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .spike_in  (spike_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_rate  (out_rate),
    .out_last  (out_last),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts per window, queue of beats still owed downstream.
  typedef struct {
    int ch;
    int rate;
    int last;
  } beat_t;

  beat_t q[$];
  beat_t nb;
  int    m_cnt [N_CH];
  int    m_pos = 0;
  int    m_ovr = 0;
  int    m_left;

  function automatic int mrate(input int n);
    int r;
    r = (n * 65536) / WIN_LEN;
    return (r > 65535) ? 65535 : r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
      m_pos = 0;
      m_ovr = 0;
    end else begin
      m_left = q.size();
      if (m_left > 0 && out_ready) begin
        q.delete(0);
        m_left--;
      end
      if (en) begin
        for (int c = 0; c < N_CH; c++) m_cnt[c] += int'(spike_in[c]);
        m_pos++;
        if (m_pos == WIN_LEN) begin
          if (m_left > 0) m_ovr = 1;
          else begin
            for (int c = 0; c < N_CH; c++) begin
              nb.ch = c;
              nb.rate = mrate(m_cnt[c]);
              nb.last = (c == N_CH - 1) ? 1 : 0;
              q.push_back(nb);
            end
          end
          for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
          m_pos = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_ch", int'(out_ch), 0);
      chk("rst_rate", int'(out_rate), 0);
      chk("rst_last", int'(out_last), 0);
      chk("rst_overrun", int'(overrun), 0);
    end else begin
      chk("valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
      chk("overrun", int'(overrun), m_ovr);
      if (q.size() > 0) begin
        chk("ch", int'(out_ch), q[0].ch);
        chk("rate", int'(out_rate), q[0].rate);
        chk("last", int'(out_last), q[0].last);
      end
    end
  end

  task automatic step(input logic e, input logic [N_CH-1:0] s, input logic r);
    en = e;
    spike_in = s;
    out_ready = r;
    @(posedge clk);
    #2;
  endtask

  logic [N_CH-1:0] s;

  initial begin
    rst = 1'b0;
    en = 1'b0;
    spike_in = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_rate", int'(out_rate), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst = 1'b1;

    // Channel 0 spikes every 3rd cycle: 11 spikes -> 0x5800.
    for (int k = 0; k < 32; k++) begin
      s = '0;
      s[0] = (k % 3 == 0);
      step(1'b1, s, 1'b1);
      if (k == 30) chk("t1_valid_before_close", int'(out_valid), 0);
    end
    chk("t1_valid_after_close", int'(out_valid), 1);
    chk("t1_beat0_ch", int'(out_ch), 0);
    chk("t1_beat0_rate", int'(out_rate), 16'h5800);

    // All ones; channel 1 misses one cycle -> 31 spikes.
    for (int k = 0; k < 32; k++) begin
      s = '1;
      if (k == 0) s[1] = 1'b0;
      step(1'b1, s, 1'b1);
      if (k == 7) chk("t1_drained", int'(out_valid), 0);
    end
    chk("t2_beat0_rate", int'(out_rate), 16'hFFFF);

    // Drain with a 5-cycle stall; new window at 16 spikes on ch 0,2,5,7.
    for (int k = 0; k < 32; k++) begin
      s = (k % 2 == 0) ? 8'hA5 : 8'h00;
      step(1'b1, s, !(k >= 3 && k <= 7));
      if (k == 0) begin
        chk("t2_beat1_ch", int'(out_ch), 1);
        chk("t2_beat1_rate", int'(out_rate), 16'hF800);
      end
      if (k >= 3 && k <= 7) begin
        chk("t3_stall_valid", int'(out_valid), 1);
        chk("t3_stall_ch", int'(out_ch), 3);
      end
      if (k == 8) chk("t3_resume_ch", int'(out_ch), 4);
    end
    chk("t3_beat0_rate", int'(out_rate), 16'h8000);

    // Last beat transfers on the closing edge of the next window.
    for (int k = 0; k < 32; k++) begin
      s = '0;
      s[0] = (k < 8);
      step(1'b1, s, (k <= 6) || (k == 31));
      if (k == 6) begin
        chk("t5_last_ch", int'(out_ch), 7);
        chk("t5_last_flag", int'(out_last), 1);
        chk("t5_last_rate", int'(out_rate), 16'h8000);
      end
    end
    chk("t5_valid_cont", int'(out_valid), 1);
    chk("t5_new_ch", int'(out_ch), 0);
    chk("t5_new_rate", int'(out_rate), 16'h4000);
    chk("t5_no_overrun", int'(overrun), 0);

    // Downstream stalled across a whole window: overrun.
    for (int k = 0; k < 32; k++) begin
      s = '0;
      s[3] = (k < 4);
      step(1'b1, s, 1'b0);
    end
    chk("t4_overrun", int'(overrun), 1);
    chk("t4_held_ch", int'(out_ch), 0);
    chk("t4_held_rate", int'(out_rate), 16'h4000);

    for (int k = 0; k < 32; k++) begin
      step(1'b1, '0, 1'b1);
      if (k == 2) begin
        chk("t4_old_ch3_ch", int'(out_ch), 3);
        chk("t4_old_ch3_rate", int'(out_rate), 0);
      end
      if (k == 7) chk("t4_drained", int'(out_valid), 0);
    end
    chk("t4_overrun_sticky", int'(overrun), 1);

    // Reset, then en toggling: window spans 64 clocks.
    rst = 1'b0;
    #1;
    chk("t6_rst_overrun", int'(overrun), 0);
    step(1'b0, '0, 1'b0);
    rst = 1'b1;
    for (int j = 0; j < 64; j++) begin
      s = 8'b0000_0100;
      if (j % 2 == 1) s = s | 8'b0001_0001;
      step(j % 2 == 0, s, 1'b0);
      if (j == 61) chk("t6_valid_early", int'(out_valid), 0);
      if (j == 62) begin
        chk("t6_valid", int'(out_valid), 1);
        chk("t6_ch0_rate", int'(out_rate), 0);
      end
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("t6_ch2_ch", int'(out_ch), 2);
    chk("t6_ch2_rate", int'(out_rate), 16'hFFFF);
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_ch", int'(out_ch), 0);
    chk("t6_rst_rate", int'(out_rate), 0);
    chk("t6_rst_last", int'(out_last), 0);
    step(1'b1, '1, 1'b1);
    step(1'b1, '1, 1'b1);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Decoder for reservoir spike trains. It is the inverse of the value-to-bitstream encoding that feeds the LIF neurons.
- Counts single-cycle spikes (the LIF i_out pulses) on N_CH channels over a fixed window of WIN_LEN enabled cycles.
- Converts each count back to a 16-bit unsigned fixed-point rate on the same scale as the NARMA y_t.
- Streams the N_CH rates out serially over a valid/ready interface to the readout/training logic.

Parameters:
- N_CH, 8, number of spike input channels (1..32).
- WIN_LEN, 32, integration window in enabled cycles; must be a power of two, 2..1024.
- CNT_W, $clog2(WIN_LEN+1), per-channel counter width (derived; not overridden).
- CH_W, $clog2(N_CH) (minimum 1), channel index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  window-advance enable; spikes are sampled only when high
- spike_in  in  N_CH  one bit per neuron; high = spike this cycle
- out_valid  out  1  rate beat available
- out_ready  in  1  downstream accepts beat
- out_ch  out  CH_W  channel index of current beat
- out_rate  out  16  rate for out_ch
- out_last  out  1  high on the final beat of a window
- overrun  out  1  sticky; a window closed while the previous one was still draining

Behaviour:
- Reset (rst low, async): all counters, shadow registers and FSM are cleared. out_valid=0, out_ch=0, out_rate=0, out_last=0, overrun=0. Reset mid-drain abandons the drain with no partial-beat guarantees.
- Accumulation (always running, independent of FSM):
  - On each cycle with en=1: cnt[c] += spike_in[c], and win_cnt increments.
  - With en=0: counters and win_cnt hold, and spikes are ignored.
  - The closing cycle is an en=1 cycle with win_cnt==WIN_LEN-1. Its spikes are included.
  - At that edge: snap[c] <= cnt[c]+spike_in[c], cnt[c] <= 0, win_cnt <= 0.
  - cnt cannot exceed WIN_LEN, so CNT_W never wraps.
- FSM states:
  - IDLE: waits for a window close, then loads the snapshot, sets out_ch=0, out_valid=1, and goes to DRAIN. out_valid is therefore visible the cycle after the closing edge.
  - DRAIN: holds out_ch/out_rate/out_last stable while out_valid && !out_ready.
    - On transfer (out_valid && out_ready), out_ch increments.
    - On transfer with out_last=1, returns to IDLE with out_valid=0.
  - out_valid never drops without a transfer.
- Rate scaling: out_rate = snap[out_ch] << (16 - log2(WIN_LEN)), saturated to 16'hFFFF.
  - The only saturating case is count==WIN_LEN.
  - Example: WIN_LEN=32, count 16 gives 16'h8000; count 32 gives 16'hFFFF.
  - Rate is combinational from the shadow register and the registered out_ch.
- out_last = out_valid && (out_ch == N_CH-1).
- Busy definition: busy = DRAIN and not (last-beat transfer this cycle).
- Window closes while busy:
  - The new snapshot is discarded.
  - overrun is set and stays set until reset.
  - The drain in progress continues unaffected.
- Window closes on the same cycle as a last-beat transfer:
  - Not an overrun.
  - The new snapshot is loaded, out_ch=0, and out_valid stays 1 continuously.
- en has no effect on an ongoing drain.
- N_CH=1: every beat has out_last=1.

Optional Feature:
- Macro: SPIKE_DEC_SUM_EN.
- When defined:
  - The drain emits one extra beat after channel N_CH-1 with out_ch=0, carrying the total population spike count (sum of snap) scaled by the same shift and saturated to 16'hFFFF.
  - out_last moves to this beat.
  - Adds internal output sum_beat (1 = current beat is the sum).
- When undefined: N_CH beats exactly, and no summing logic is synthesized.

Decomposition:
- Shared package (spike_dec_pkg):
  - FSM state enum (IDLE, DRAIN).
  - Fixed-point constant RATE_W=16.
  - Function for the saturating shift scale, reused by the sum beat.
- One natural sub-module: spike_win_counter. It holds the per-channel counters, win_cnt and snapshot generation, outputs a close pulse plus snap vector, and is instantiated once.

Test Plan:
- Reset, then en=1 with spike_in[0] high every 3rd cycle and others 0, WIN_LEN=32 → closing cycle is the 32nd, so 11 spikes. Beat 0 gives out_rate=16'h5800; beats 1..7 give 0. out_last is on out_ch=7, and out_valid rises the cycle after the closing edge.
- spike_in all-ones for 32 cycles → all 8 beats give 16'hFFFF (saturation); a 31-spike channel gives 16'hF800.
- out_ready low for 5 cycles mid-drain → out_ch/out_rate held stable and out_valid held high. Beats resume in order with none dropped or duplicated.
- out_ready held low past the next window close → overrun=1 and the first window's data is drained unchanged. The second window's snapshot is never emitted, and overrun stays 1 until rst.
- Last-beat transfer aligned to the closing cycle → overrun stays 0, out_valid stays continuously 1, and the next beat is out_ch=0 with new data.
- Toggle en (alternate cycles) → window takes 64 clocks and only enabled-cycle spikes count. Then assert rst low mid-drain → all outputs go 0 immediately.
